// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
//   - Default geometry: address width, instruction width, index bits.
//   - Controller state encoding (IC_IDLE / IC_FETCH / IC_ABORT).
package icache_pkg;

  localparam int unsigned ICACHE_ADDR_WIDTH = 32;
  localparam int unsigned ICACHE_INST_WIDTH = 32;
  localparam int unsigned ICACHE_INDEX_BITS = 6;

  typedef enum logic [1:0] {
    IC_IDLE  = 2'd0,  // serving hits, may launch a miss
    IC_FETCH = 2'd1,  // miss outstanding, word will be forwarded to fetch
    IC_ABORT = 2'd2   // miss outstanding, forward cancelled by a flush
  } ic_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache, one word per line.
// Hits are answered combinationally from the line arrays. A miss issues a
// single-word read to the memory controller, fills the line and forwards the
// returned word to fetch one cycle after the memory pulse. A flush during a
// miss cancels the forward but the memory read still completes and fills.
//
// Ports:
//   clk, rst_in      clock, synchronous active-high reset
//   rdy_in           global ready; low freezes all state
//   next_PC          fetch address (bits [1:0] ignored)
//   next_inst        fetch request strobe
//   flush            pipeline flush
//   cache_rdy        hit this cycle (combinational)
//   inst_out_cache   hit data
//   mem_rdy          one-cycle pulse: miss data forwarded
//   inst_out_mem     forwarded fill data (registered)
//   ic2mem_en        memory read request, level-held
//   ic2mem_addr      word-aligned miss address
//   mem2ic_rdy       memory read data valid pulse
//   mem2ic_data      memory read data
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int INST_WIDTH = ICACHE_INST_WIDTH,
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [ADDR_WIDTH-1:0] next_PC,
  input  logic                  next_inst,
  input  logic                  flush,
  output logic                  cache_rdy,
  output logic [INST_WIDTH-1:0] inst_out_cache,
  output logic                  mem_rdy,
  output logic [INST_WIDTH-1:0] inst_out_mem,
  output logic                  ic2mem_en,
  output logic [ADDR_WIDTH-1:0] ic2mem_addr,
  input  logic                  mem2ic_rdy,
  input  logic [INST_WIDTH-1:0] mem2ic_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  // Line storage: valid bits are reset, tag and data arrays are not.
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [INST_WIDTH-1:0] data_q [LINES];

  ic_state_e             state_q, state_d;
  logic                  ic2mem_en_q, ic2mem_en_d;
  logic [ADDR_WIDTH-1:0] ic2mem_addr_q, ic2mem_addr_d;
  logic                  mem_rdy_q, mem_rdy_d;
  logic [INST_WIDTH-1:0] inst_out_mem_q, inst_out_mem_d;
  logic                  fill_we;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  line_hit;
  logic                  pc_offset_unused;

  assign req_idx  = next_PC[INDEX_BITS+1:2];
  assign req_tag  = next_PC[ADDR_WIDTH-1:INDEX_BITS+2];
  // The line being filled is named by the latched miss address, not by
  // whatever fetch is presenting now.
  assign fill_idx = ic2mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = ic2mem_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];

  // Byte offset within the word plays no part in lookup.
  assign pc_offset_unused = ^next_PC[1:0];

  assign line_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign cache_rdy      = rdy_in && next_inst && (state_q == IC_IDLE) && line_hit;
  assign inst_out_cache = data_q[req_idx];
  // The forward pulse is held in its register while stalled and only shown
  // once the pipeline is ready to take it.
  assign mem_rdy        = rdy_in && mem_rdy_q;
  assign inst_out_mem   = inst_out_mem_q;
  assign ic2mem_en      = ic2mem_en_q;
  assign ic2mem_addr    = ic2mem_addr_q;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    ic2mem_en_d    = ic2mem_en_q;
    ic2mem_addr_d  = ic2mem_addr_q;
    mem_rdy_d      = 1'b0;
    inst_out_mem_d = inst_out_mem_q;
    fill_we        = 1'b0;

    case (state_q)
      IC_IDLE: begin
        // A flush in IDLE only suppresses the launch; a hit is still shown.
        if (next_inst && !line_hit && !flush) begin
          ic2mem_addr_d = {next_PC[ADDR_WIDTH-1:2], 2'b00};
          ic2mem_en_d   = 1'b1;
          state_d       = IC_FETCH;
        end
      end

      IC_FETCH: begin
        if (mem2ic_rdy) begin
          fill_we     = 1'b1;
          ic2mem_en_d = 1'b0;
          state_d     = IC_IDLE;
          // A flush arriving with the data still fills but drops the forward.
          if (!flush) begin
            mem_rdy_d      = 1'b1;
            inst_out_mem_d = mem2ic_data;
          end
        end else if (flush) begin
          state_d = IC_ABORT;
        end
      end

      IC_ABORT: begin
        if (mem2ic_rdy) begin
          fill_we     = 1'b1;
          ic2mem_en_d = 1'b0;
          state_d     = IC_IDLE;
        end
      end

      default: begin
        ic2mem_en_d = 1'b0;
        state_d     = IC_IDLE;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q        <= IC_IDLE;
      ic2mem_en_q    <= 1'b0;
      ic2mem_addr_q  <= '0;
      mem_rdy_q      <= 1'b0;
      inst_out_mem_q <= '0;
      valid_q        <= '0;
    end else if (rdy_in) begin
      state_q        <= state_d;
      ic2mem_en_q    <= ic2mem_en_d;
      ic2mem_addr_q  <= ic2mem_addr_d;
      mem_rdy_q      <= mem_rdy_d;
      inst_out_mem_q <= inst_out_mem_d;
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; a cleared valid bit already
  // hides stale contents, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (!rst_in && rdy_in && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem2ic_data;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache. A behavioural model keeps, per line, the
// cached word address and data; memory contents come from a fixed hash with
// optional overrides. Directed scenarios are followed by randomized misses,
// hits, flushes and stalls.
module tb_icache;
  import icache_pkg::*;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int NLINES = 64;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic [AW-1:0] next_PC;
  logic          next_inst;
  logic          flush;
  logic          cache_rdy;
  logic [IW-1:0] inst_out_cache;
  logic          mem_rdy;
  logic [IW-1:0] inst_out_mem;
  logic          ic2mem_en;
  logic [AW-1:0] ic2mem_addr;
  logic          mem2ic_rdy;
  logic [IW-1:0] mem2ic_data;

  int n_checks = 0;
  int n_errors = 0;

  // Model: what word each line holds, if any.
  bit          mdl_valid [NLINES];
  logic [29:0] mdl_word  [NLINES];
  logic [31:0] mdl_data  [NLINES];
  logic [31:0] mem_override [logic [31:0]];

  icache dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .next_PC        (next_PC),
    .next_inst      (next_inst),
    .flush          (flush),
    .cache_rdy      (cache_rdy),
    .inst_out_cache (inst_out_cache),
    .mem_rdy        (mem_rdy),
    .inst_out_mem   (inst_out_mem),
    .ic2mem_en      (ic2mem_en),
    .ic2mem_addr    (ic2mem_addr),
    .mem2ic_rdy     (mem2ic_rdy),
    .mem2ic_data    (mem2ic_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] waddr);
    if (mem_override.exists(waddr)) return mem_override[waddr];
    return (waddr * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic bit mdl_hit(input logic [31:0] addr);
    int idx;
    idx = int'(addr[7:2]);
    return mdl_valid[idx] && (mdl_word[idx] == addr[31:2]);
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_quiet();
    rdy_in      = 1'b1;
    next_inst   = 1'b0;
    flush       = 1'b0;
    mem2ic_rdy  = 1'b0;
    mem2ic_data = $urandom;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NLINES; i++) mdl_valid[i] = 1'b0;
  endtask

  // One fetch transaction starting in an IDLE cycle. lat: FETCH cycles before
  // memory answers; flush_at: FETCH cycle index carrying a flush (-1 none);
  // stall: rdy_in-low cycles inserted after the first FETCH cycle;
  // flush_idle: flush asserted alongside the request itself.
  task automatic fetch(input logic [31:0] addr, input int lat, input int flush_at,
                       input int stall, input bit flush_idle);
    logic [31:0] waddr;
    int          idx;
    bit          hit;
    bit          aborted;
    bit          done;
    int          n;
    int          stalls_left;
    int          guard;
    logic [31:0] data;

    waddr       = {addr[31:2], 2'b00};
    idx         = int'(addr[7:2]);
    hit         = mdl_hit(addr);
    data        = mem_word(waddr);
    aborted     = (flush_at >= 0) && (flush_at <= lat);
    stalls_left = stall;
    n           = 0;
    guard       = 0;
    done        = 1'b0;

    rdy_in      = 1'b1;
    next_PC     = addr;
    next_inst   = 1'b1;
    flush       = flush_idle;
    mem2ic_rdy  = 1'b0;
    mem2ic_data = $urandom;
    #2;
    check("req_cache_rdy", 32'(cache_rdy), 32'(hit));
    if (hit) check("req_hit_data", inst_out_cache, mdl_data[idx]);
    check("req_mem_rdy", 32'(mem_rdy), 32'd0);
    check("req_en_idle", 32'(ic2mem_en), 32'd0);
    tick();

    if (hit) return;
    if (flush_idle) begin
      drive_quiet();
      #2;
      check("flush_idle_no_miss", 32'(ic2mem_en), 32'd0);
      tick();
      return;
    end

    while (!done) begin
      guard++;
      if (guard > 200) begin
        check("miss_timeout", 32'd1, 32'd0);
        return;
      end
      next_PC   = rand_pc();
      next_inst = 1'($urandom_range(0, 1));
      if (n == 1 && stalls_left > 0) begin
        rdy_in      = 1'b0;
        flush       = 1'b0;
        mem2ic_rdy  = 1'b0;
        mem2ic_data = $urandom;
        #2;
        check("stall_cache_rdy", 32'(cache_rdy), 32'd0);
        check("stall_mem_rdy", 32'(mem_rdy), 32'd0);
        check("stall_en", 32'(ic2mem_en), 32'd1);
        check("stall_addr", ic2mem_addr, waddr);
        stalls_left--;
      end else begin
        rdy_in      = 1'b1;
        flush       = (n == flush_at);
        mem2ic_rdy  = (n == lat);
        mem2ic_data = (n == lat) ? data : $urandom;
        #2;
        check("wait_cache_rdy", 32'(cache_rdy), 32'd0);
        check("wait_mem_rdy", 32'(mem_rdy), 32'd0);
        check("wait_en", 32'(ic2mem_en), 32'd1);
        check("wait_addr", ic2mem_addr, waddr);
        if (n == lat) done = 1'b1;
        n++;
      end
      tick();
    end

    drive_quiet();
    #2;
    check("fill_mem_rdy", 32'(mem_rdy), 32'(!aborted));
    if (!aborted) check("fill_data", inst_out_mem, data);
    check("fill_en_low", 32'(ic2mem_en), 32'd0);
    mdl_valid[idx] = 1'b1;
    mdl_word[idx]  = addr[31:2];
    mdl_data[idx]  = data;
    tick();
  endtask

  initial begin
    rst_in  = 1'b1;
    next_PC = '0;
    drive_quiet();
    mdl_clear();
    mem_override[32'h0000_0000] = 32'h0000_0513;
    tick();
    tick();
    rst_in = 1'b0;
    #2;
    check("rst_cache_rdy", 32'(cache_rdy), 32'd0);
    check("rst_mem_rdy", 32'(mem_rdy), 32'd0);
    check("rst_en", 32'(ic2mem_en), 32'd0);
    check("rst_addr", ic2mem_addr, 32'd0);
    check("rst_inst_out_mem", inst_out_mem, 32'd0);
    tick();

    // Cold miss, fill after 3 cycles, then a hit on the same word.
    fetch(32'h0000_0000, 3, -1, 0, 1'b0);
    fetch(32'h0000_0000, 0, -1, 0, 1'b0);
    check("hit_known_word", mdl_data[0], 32'h0000_0513);

    // Conflict on index 1: 0x104 evicts 0x004.
    fetch(32'h0000_0004, 1, -1, 0, 1'b0);
    fetch(32'h0000_0104, 2, -1, 0, 1'b0);
    fetch(32'h0000_0004, 1, -1, 0, 1'b0);

    // Flush two cycles into a miss; the line still fills.
    fetch(32'h0000_0008, 5, 2, 0, 1'b0);
    fetch(32'h0000_0008, 0, -1, 0, 1'b0);

    // Flush coinciding with the memory pulse.
    fetch(32'h0000_000C, 3, 3, 0, 1'b0);
    fetch(32'h0000_000C, 0, -1, 0, 1'b0);

    // Global stall mid-FETCH with memory held off.
    fetch(32'h0000_0010, 3, -1, 5, 1'b0);
    fetch(32'h0000_0010, 0, -1, 0, 1'b0);

    // Flush in IDLE: miss not launched, hit still reported.
    fetch(32'h0000_0020, 2, -1, 0, 1'b1);
    fetch(32'h0000_0000, 0, -1, 0, 1'b1);

    // Reset during FETCH drops the request and invalidates every line.
    rdy_in      = 1'b1;
    next_PC     = 32'h0000_0300;
    next_inst   = 1'b1;
    flush       = 1'b0;
    mem2ic_rdy  = 1'b0;
    #2;
    check("pre_rst_cache_rdy", 32'(cache_rdy), 32'(mdl_hit(32'h0000_0300)));
    tick();
    drive_quiet();
    #2;
    check("pre_rst_en", 32'(ic2mem_en), 32'd1);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    #2;
    check("midrst_en", 32'(ic2mem_en), 32'd0);
    check("midrst_addr", ic2mem_addr, 32'd0);
    check("midrst_mem_rdy", 32'(mem_rdy), 32'd0);
    mdl_clear();
    tick();
    fetch(32'h0000_0000, 2, -1, 0, 1'b0);

    // Randomized traffic over a small address pool.
    for (int i = 0; i < 150; i++) begin
      int lat;
      int fat;
      int stl;
      bit fid;
      lat = $urandom_range(0, 4);
      fat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat)) : -1;
      stl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      fid = ($urandom_range(0, 9) == 0);
      fetch(rand_pc(), lat, fat, stl, fid);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
